stopwatch_sequencer: RTL
========================

# stopwatch_sequencer

Sequencing controller for the stopwatch datapath. It converts the level-sensitive `start`, `stop`, `clear` and `lap` button inputs into single-cycle events and runs the IDLE/RUNNING/PAUSED state machine. It also generates the one-second tick from the system clock and drives the mm:ss BCD time counter and the lap-hold display register. It sits between the button/synchroniser layer and the display driver, and replaces the bare enable-only control FSM as the owner of the run/pause sequencing.

## Interface
Parameters:
- `TICKS_PER_SEC`, default 100: clock cycles per counted second. Legal range is ≥2.

Ports:
- `clk`, in, 1: system clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `start`, in, 1: run request, level input, already synchronised; acts on its rising edge.
- `stop`, in, 1: pause request; acts on its rising edge.
- `clear`, in, 1: zero request; acts on its rising edge.
- `lap`, in, 1: lap freeze/release; acts on its rising edge.
- `enable`, out, 1: high while in RUNNING.
- `state`, out, 2: 0=IDLE, 1=RUNNING, 2=PAUSED; 3 is never driven.
- `sec_tick`, out, 1: one-cycle pulse each counted second.
- `time_bcd`, out, 16: live time `{min_tens, min_ones, sec_tens, sec_ones}`, 4 bits per digit.
- `disp_bcd`, out, 16: `lap_bcd` while `lap_hold`=1, otherwise `time_bcd`.
- `lap_hold`, out, 1: display frozen on the captured lap value.

## Operation
- **Edge detection.** Each button has a `*_q` register holding the previous sample. The event is `in & ~in_q`. A held button produces exactly one event. `*_q` resets to 0, so a button held high across reset release fires on the first edge.
- **State machine**, reset state IDLE:
  - IDLE: a start event goes to RUNNING.
  - RUNNING: a stop event goes to PAUSED. Clear events are ignored.
  - PAUSED: a start event goes to RUNNING. A clear event goes to IDLE.
  - IDLE: a clear event re-zeroes the counters; the state is unchanged.
  - Start and stop events on the same edge while RUNNING: stop wins, go to PAUSED. In IDLE or PAUSED, start wins.
- **Prescaler.** Width is `$clog2(TICKS_PER_SEC)`.
  - RUNNING: counts 0..`TICKS_PER_SEC`-1 and wraps to 0.
  - PAUSED: holds its value (partial second preserved).
  - IDLE: forced to 0.
- **Time counter.** Increments only on an edge where the state is RUNNING and the prescaler equals `TICKS_PER_SEC`-1.
  - Digit moduli: sec_ones 10, sec_tens 6, min_ones 10, min_tens 6. Each carry ripples within the same edge.
  - 59:59 wraps to 00:00 with no flag. Digit values stay ≤9 / ≤5 at all times.
- **Clear.** A clear event (in IDLE or PAUSED) zeroes the time counter, the prescaler and `lap_hold`.
- **Lap.**
  - RUNNING with `lap_hold`=0: a lap event copies `time_bcd` into `lap_bcd` and sets `lap_hold`. The counter keeps running.
  - RUNNING or PAUSED with `lap_hold`=1: a lap event clears `lap_hold`.
  - IDLE: lap events are ignored.
  - If a lap capture coincides with an increment, `lap_bcd` takes the pre-increment value.

## Timing
- **Reset values.**
  - `state`=IDLE, `enable`=0, `sec_tick`=0, `lap_hold`=0.
  - `time_bcd`=`disp_bcd`=16'h0000; `lap_bcd`=0; prescaler=0.
  - Reset asserted mid-run clears everything immediately, without waiting for a clock edge.
- **Event latency.** With `start` sampled high at edge k (and low at k-1), `state` and `enable` change after edge k. `stop` and `clear` behave the same.
- **First tick.** From IDLE, with a start event at edge k, the first increment occurs at edge k+`TICKS_PER_SEC`.
- **`sec_tick`.** Registered. High for exactly the one cycle following the incrementing edge, coincident with the new `time_bcd`.
- **Pause/resume.** A pause at prescaler value p, followed by a resume, increments after `TICKS_PER_SEC`-p further RUNNING edges.
- **`disp_bcd`.** Combinational mux of registered values; zero added latency.

## Structure
- Package `stopwatch_pkg`:
  - state encodings `ST_IDLE`/`ST_RUNNING`/`ST_PAUSED`;
  - `BCD_W`=4 and digit moduli constants.
- Sub-module `bcd_digit_counter`:
  - parameter `MODULO`; ports `clk`, `rst_n`, `clr`, `inc`, `digit[3:0]`, `carry`;
  - instantiated four times in a ripple chain.
- Top-level holds the edge detectors, the FSM, the prescaler, the lap register and the output mux.

## Test plan
Run with `TICKS_PER_SEC`=4.
1. **Reset.** Hold `rst_n`=0 for 2 cycles, then release. Required: `state`=0, `enable`=0, `time_bcd`=0000, `sec_tick`=0. Then start high 1 cycle. Required: `enable`=1 after that edge, `sec_tick` pulses every 4 cycles, `time_bcd` goes 0001, 0002, and so on.
2. **Pause/resume.**
   - Run 10 s (`time_bcd`=0010), pulse stop. Required: `state`=2, time frozen for 50 cycles, no `sec_tick`.
   - Pulse start. Required: increment to 0011 after the remaining prescaler count, not 4 full cycles.
3. **Rollover.** Run 3599 s, then one more second. Required: 5959 becomes 0000, `sec_tick` pulses, `state` stays RUNNING.
4. **Lap.**
   - At 0005, pulse lap. Required: `lap_hold`=1, `disp_bcd`=0005 while `time_bcd` advances to 0008.
   - Pulse lap again. Required: `disp_bcd`=`time_bcd`.
5. **Conflicts and clear.**
   - start+stop on the same edge while RUNNING. Required: PAUSED.
   - clear while RUNNING. Required: ignored, counting continues.
   - clear while PAUSED. Required: IDLE with 0000.
   - start held high for 20 cycles. Required: one transition only.
6. **Async reset.** Assert `rst_n` low mid-cycle while RUNNING at 0123. Required: all outputs zero before the next clock edge. After release: IDLE, no counting until a start event.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch sequencer and its BCD digit chain.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2
  } state_e;

  localparam int BCD_W = 4;

  localparam int SEC_ONES_MOD = 10;
  localparam int SEC_TENS_MOD = 6;
  localparam int MIN_ONES_MOD = 10;
  localparam int MIN_TENS_MOD = 6;

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MODULO-1. Carry is combinational so a whole
// chain of digits ripples within a single clock edge.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter int MODULO = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] digit,
  output logic             carry
);

  localparam logic [BCD_W-1:0] DIGIT_MAX = BCD_W'(MODULO - 1);

  logic [BCD_W-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == DIGIT_MAX) ? '0 : digit_q + BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc && (digit_q == DIGIT_MAX);

endmodule

// File: rtl/stopwatch_sequencer.sv
// Stopwatch run/pause sequencer: button edge detection, IDLE/RUNNING/PAUSED FSM,
// one-second prescaler, mm:ss BCD counter and lap-hold display register.
module stopwatch_sequencer
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        lap,
  output logic        enable,
  output logic [1:0]  state,
  output logic        sec_tick,
  output logic [15:0] time_bcd,
  output logic [15:0] disp_bcd,
  output logic        lap_hold
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  logic start_q, start_d, stop_q, stop_d, clear_q, clear_d, lap_q, lap_d;
  logic start_evt, stop_evt, clear_evt, lap_evt;

  always_comb begin
    start_d = start;
    stop_d  = stop;
    clear_d = clear;
    lap_d   = lap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
      lap_q   <= 1'b0;
    end else begin
      start_q <= start_d;
      stop_q  <= stop_d;
      clear_q <= clear_d;
      lap_q   <= lap_d;
    end
  end

  assign start_evt = start & ~start_q;
  assign stop_evt  = stop  & ~stop_q;
  assign clear_evt = clear & ~clear_q;
  assign lap_evt   = lap   & ~lap_q;

  state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stop beats start while running; start beats clear while paused.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start_evt) state_d = ST_RUNNING;
      ST_RUNNING: if (stop_evt)  state_d = ST_PAUSED;
      ST_PAUSED: begin
        if (start_evt)      state_d = ST_RUNNING;
        else if (clear_evt) state_d = ST_IDLE;
      end
      default:            state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enable = (state_q == ST_RUNNING);
    state  = state_q;
  end

  logic clr_do;
  logic tick_inc;
  logic [PW-1:0] presc_q, presc_d;

  assign clr_do   = clear_evt &&
                    ((state_q == ST_IDLE) || ((state_q == ST_PAUSED) && !start_evt));
  assign tick_inc = (state_q == ST_RUNNING) && (presc_q == PRE_MAX);

  // PAUSED holds the partial second so a resume finishes it rather than restarting it.
  always_comb begin
    presc_d = presc_q;
    if (clr_do || (state_q == ST_IDLE)) begin
      presc_d = '0;
    end else if (state_q == ST_RUNNING) begin
      presc_d = tick_inc ? '0 : presc_q + PW'(1);
    end
  end

  logic sec_tick_q, sec_tick_d;

  always_comb sec_tick_d = tick_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign sec_tick = sec_tick_q;

  logic [BCD_W-1:0] sec_ones, sec_tens, min_ones, min_tens;
  logic so_carry, st_carry, mo_carry, wrap_carry_unused;

  bcd_digit_counter #(.MODULO(SEC_ONES_MOD)) u_sec_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr_do), .inc(tick_inc),
    .digit(sec_ones), .carry(so_carry)
  );

  bcd_digit_counter #(.MODULO(SEC_TENS_MOD)) u_sec_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr_do), .inc(so_carry),
    .digit(sec_tens), .carry(st_carry)
  );

  bcd_digit_counter #(.MODULO(MIN_ONES_MOD)) u_min_ones (
    .clk(clk), .rst_n(rst_n), .clr(clr_do), .inc(st_carry),
    .digit(min_ones), .carry(mo_carry)
  );

  // 59:59 wraps silently, so the top digit's carry goes nowhere.
  bcd_digit_counter #(.MODULO(MIN_TENS_MOD)) u_min_tens (
    .clk(clk), .rst_n(rst_n), .clr(clr_do), .inc(mo_carry),
    .digit(min_tens), .carry(wrap_carry_unused)
  );

  assign time_bcd = {min_tens, min_ones, sec_tens, sec_ones};

  logic [15:0] lap_bcd_q, lap_bcd_d;
  logic        lap_hold_q, lap_hold_d;

  // Capture uses the registered time, i.e. the value before any same-edge increment.
  always_comb begin
    lap_bcd_d  = lap_bcd_q;
    lap_hold_d = lap_hold_q;
    if (clr_do) begin
      lap_hold_d = 1'b0;
    end else if (lap_evt) begin
      if ((state_q == ST_RUNNING) && !lap_hold_q) begin
        lap_bcd_d  = time_bcd;
        lap_hold_d = 1'b1;
      end else if ((state_q != ST_IDLE) && lap_hold_q) begin
        lap_hold_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_bcd_q  <= '0;
      lap_hold_q <= 1'b0;
    end else begin
      lap_bcd_q  <= lap_bcd_d;
      lap_hold_q <= lap_hold_d;
    end
  end

  assign lap_hold = lap_hold_q;
  assign disp_bcd = lap_hold_q ? lap_bcd_q : time_bcd;

endmodule
